// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised raster timing generator. It produces sync, blank and pixel
//   coordinates for any video mode described by the porch, sync and active
//   parameters. The counters advance on Clk edges where Pix_En is high. It also
//   provides line and frame start strobes.
//
//   Optional feature: define VGA_LINE_MATCH_EN to add Match_Y / line_match.
//
// Ports
//   Clk          in   system clock
//   Reset_N      in   synchronous active-low reset
//   Pix_En       in   pixel strobe; counters step only when high
//   VGA_HS       out  horizontal sync, asserted level = HS_POL
//   VGA_VS       out  vertical sync, asserted level = VS_POL
//   VGA_BLANK_N  out  1 = visible pixel
//   VGA_SYNC_N   out  composite sync, tied 0
//   DrawX        out  current horizontal position
//   DrawY        out  current vertical position
//   new_line     out  one-Clk pulse when DrawX becomes 0
//   new_frame    out  one-Clk pulse when (DrawX,DrawY) becomes (0,0)
//   Match_Y      in   (VGA_LINE_MATCH_EN) line number to flag
//   line_match   out  (VGA_LINE_MATCH_EN) pulse with new_line when DrawY == Match_Y
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CW       = 10
) (
    input  logic          Clk,
    input  logic          Reset_N,
    input  logic          Pix_En,
`ifdef VGA_LINE_MATCH_EN
    input  logic [CW-1:0] Match_Y,
    output logic          line_match,
`endif
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_BLANK_N,
    output logic          VGA_SYNC_N,
    output logic [CW-1:0] DrawX,
    output logic [CW-1:0] DrawY,
    output logic          new_line,
    output logic          new_frame
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    logic [CW-1:0] h_q, h_d, v_q, v_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic          hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
    logic          new_line_q, new_line_d, new_frame_q, new_frame_d;
`ifdef VGA_LINE_MATCH_EN
    logic          line_match_q, line_match_d;
`endif

    // Outputs are decoded from the post-step counter value (h_d/v_d). This
    // keeps coordinates, syncs, blank and strobes aligned to the same pixel.
    always_comb begin
        h_d         = h_q;
        v_d         = v_q;
        x_d         = x_q;
        y_d         = y_q;
        hs_d        = hs_q;
        vs_d        = vs_q;
        blank_n_d   = blank_n_q;
        new_line_d  = 1'b0;
        new_frame_d = 1'b0;
`ifdef VGA_LINE_MATCH_EN
        line_match_d = 1'b0;
`endif
        if (Pix_En) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
            end else begin
                h_d = h_q + CW'(1);
            end
            x_d         = h_d;
            y_d         = v_d;
            hs_d        = (32'(h_d) >= HS_START && 32'(h_d) < HS_END) ? HS_POL : ~HS_POL;
            vs_d        = (32'(v_d) >= VS_START && 32'(v_d) < VS_END) ? VS_POL : ~VS_POL;
            blank_n_d   = (32'(h_d) < H_ACTIVE) && (32'(v_d) < V_ACTIVE);
            new_line_d  = (h_d == '0);
            new_frame_d = (h_d == '0) && (v_d == '0);
`ifdef VGA_LINE_MATCH_EN
            // v_d never exceeds V_TOTAL-1, so an out-of-range Match_Y cannot fire.
            line_match_d = (h_d == '0) && (v_d == Match_Y);
`endif
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            // The counters reload to the last position so the first step lands on (0,0).
            h_q         <= H_LAST;
            v_q         <= V_LAST;
            x_q         <= '0;
            y_q         <= '0;
            hs_q        <= ~HS_POL;
            vs_q        <= ~VS_POL;
            blank_n_q   <= 1'b0;
            new_line_q  <= 1'b0;
            new_frame_q <= 1'b0;
`ifdef VGA_LINE_MATCH_EN
            line_match_q <= 1'b0;
`endif
        end else begin
            h_q         <= h_d;
            v_q         <= v_d;
            x_q         <= x_d;
            y_q         <= y_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            blank_n_q   <= blank_n_d;
            new_line_q  <= new_line_d;
            new_frame_q <= new_frame_d;
`ifdef VGA_LINE_MATCH_EN
            line_match_q <= line_match_d;
`endif
        end
    end

    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_SYNC_N  = 1'b0;
    assign new_line    = new_line_q;
    assign new_frame   = new_frame_q;
`ifdef VGA_LINE_MATCH_EN
    assign line_match  = line_match_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Bench for vga_timing_gen. It drives two instances from shared stimulus:
//   the default 640x480 mode, and a tiny 16x7 mode with a positive HS. The
//   expected outputs come from the number of pixel steps since reset, using
//   division and modulo on the mode geometry. Line-match checks are active
//   when VGA_LINE_MATCH_EN is defined.
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pix_en;
    logic [9:0] match_y;

    logic       d0_hs, d0_vs, d0_bn, d0_sn, d0_nl, d0_nf, d0_lm;
    logic [9:0] d0_x, d0_y;
    logic       d1_hs, d1_vs, d1_bn, d1_sn, d1_nl, d1_nf, d1_lm;
    logic [9:0] d1_x, d1_y;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    // Reference state: pixel steps since reset, whether the last edge stepped,
    // and the Match_Y value captured on that edge.
    int         steps   = 0;
    bit         stepped = 1'b0;
    logic [9:0] mstep   = '0;

    always #5 clk = ~clk;

    vga_timing_gen u_d0 (
        .Clk(clk), .Reset_N(rst_n), .Pix_En(pix_en),
`ifdef VGA_LINE_MATCH_EN
        .Match_Y(match_y), .line_match(d0_lm),
`endif
        .VGA_HS(d0_hs), .VGA_VS(d0_vs), .VGA_BLANK_N(d0_bn), .VGA_SYNC_N(d0_sn),
        .DrawX(d0_x), .DrawY(d0_y), .new_line(d0_nl), .new_frame(d0_nf)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0), .CW(10)
    ) u_d1 (
        .Clk(clk), .Reset_N(rst_n), .Pix_En(pix_en),
`ifdef VGA_LINE_MATCH_EN
        .Match_Y(match_y), .line_match(d1_lm),
`endif
        .VGA_HS(d1_hs), .VGA_VS(d1_vs), .VGA_BLANK_N(d1_bn), .VGA_SYNC_N(d1_sn),
        .DrawX(d1_x), .DrawY(d1_y), .new_line(d1_nl), .new_frame(d1_nf)
    );

`ifndef VGA_LINE_MATCH_EN
    assign d0_lm = 1'b0;
    assign d1_lm = 1'b0;
`endif

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs for a mode, given the number of steps since reset.
    function automatic void model(
        input int steps_i, input bit stepped_i, input int my,
        input int ha, input int hfp, input int hsw, input int hbp,
        input int va, input int vfp, input int vsw, input int vbp,
        input bit hpol, input bit vpol,
        output int ex, output int ey,
        output bit hs, output bit vs, output bit bn,
        output bit nl, output bit nf, output bit lm);
        int ht, vt, s, x, y;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        if (steps_i == 0) begin
            ex = 0; ey = 0; hs = ~hpol; vs = ~vpol; bn = 1'b0;
            nl = 1'b0; nf = 1'b0; lm = 1'b0;
        end else begin
            s  = steps_i - 1;
            x  = s % ht;
            y  = (s / ht) % vt;
            ex = x;
            ey = y;
            hs = (x >= ha + hfp && x < ha + hfp + hsw) ? hpol : ~hpol;
            vs = (y >= va + vfp && y < va + vfp + vsw) ? vpol : ~vpol;
            bn = (x < ha) && (y < va);
            nl = stepped_i && (x == 0);
            nf = nl && (y == 0);
            lm = nl && (y == my);
        end
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            steps   <= 0;
            stepped <= 1'b0;
        end else begin
            stepped <= pix_en;
            if (pix_en) steps <= steps + 1;
        end
        mstep <= match_y;
    end

    always @(negedge clk) begin
        int ex, ey;
        bit hs, vs, bn, nl, nf, lm;
        if (check_en) begin
            model(steps, stepped, int'(mstep), 640, 16, 96, 48, 480, 10, 2, 33,
                  1'b0, 1'b0, ex, ey, hs, vs, bn, nl, nf, lm);
            check("d0_x", int'(d0_x), ex);
            check("d0_y", int'(d0_y), ey);
            check("d0_hs", int'(d0_hs), int'(hs));
            check("d0_vs", int'(d0_vs), int'(vs));
            check("d0_blank_n", int'(d0_bn), int'(bn));
            check("d0_sync_n", int'(d0_sn), 0);
            check("d0_new_line", int'(d0_nl), int'(nl));
            check("d0_new_frame", int'(d0_nf), int'(nf));
`ifdef VGA_LINE_MATCH_EN
            check("d0_line_match", int'(d0_lm), int'(lm));
`endif
            model(steps, stepped, int'(mstep), 8, 2, 3, 3, 4, 1, 1, 1,
                  1'b1, 1'b0, ex, ey, hs, vs, bn, nl, nf, lm);
            check("d1_x", int'(d1_x), ex);
            check("d1_y", int'(d1_y), ey);
            check("d1_hs", int'(d1_hs), int'(hs));
            check("d1_vs", int'(d1_vs), int'(vs));
            check("d1_blank_n", int'(d1_bn), int'(bn));
            check("d1_new_line", int'(d1_nl), int'(nl));
            check("d1_new_frame", int'(d1_nf), int'(nf));
`ifdef VGA_LINE_MATCH_EN
            check("d1_line_match", int'(d1_lm), int'(lm));
`endif
        end
    end

    task automatic run(input int n, input bit toggle);
        for (int i = 0; i < n; i++) begin
            pix_en = toggle ? ~pix_en : 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        int k;
        rst_n    = 1'b0;
        pix_en   = 1'b0;
        match_y  = 10'd5;
        check_en = 1'b1;

        // Reset is held for 3 clocks. Both instances must show reset values.
        repeat (3) @(negedge clk);
        check("rst_d0_x", int'(d0_x), 0);
        check("rst_d0_hs", int'(d0_hs), 1);
        check("rst_d0_blank_n", int'(d0_bn), 0);
        check("rst_d1_hs", int'(d1_hs), 0);

        // The first step after release lands on (0,0) with both strobes.
        rst_n  = 1'b1;
        pix_en = 1'b1;
        @(negedge clk);
        check("first_x", int'(d0_x), 0);
        check("first_y", int'(d0_y), 0);
        check("first_new_line", int'(d0_nl), 1);
        check("first_new_frame", int'(d0_nf), 1);
        check("first_blank_n", int'(d0_bn), 1);

        // With Pix_En low, the strobes clear and the position holds.
        pix_en = 1'b0;
        @(negedge clk);
        check("hold_new_line", int'(d0_nl), 0);
        check("hold_new_frame", int'(d0_nf), 0);
        check("hold_x", int'(d0_x), 0);

        // Check the HS boundaries and the blank boundary on the default mode.
        run(655, 1'b0);
        check("x655", int'(d0_x), 655);
        check("x655_hs", int'(d0_hs), 1);
        check("x655_blank_n", int'(d0_bn), 0);
        run(1, 1'b0);
        check("x656_hs", int'(d0_hs), 0);
        run(95, 1'b0);
        check("x751", int'(d0_x), 751);
        check("x751_hs", int'(d0_hs), 0);
        run(1, 1'b0);
        check("x752_hs", int'(d0_hs), 1);
        run(47, 1'b0);
        check("x799", int'(d0_x), 799);
        run(1, 1'b0);
        check("wrap_x", int'(d0_x), 0);
        check("wrap_y", int'(d0_y), 1);
        check("wrap_new_line", int'(d0_nl), 1);
        check("wrap_new_frame", int'(d0_nf), 0);

        // Run at full rate. The tiny mode wraps through many frames.
        run(2000, 1'b0);
        // Pix_En one-of-two: outputs freeze on idle cycles, and strobes stay 1 clk wide.
        pix_en = 1'b1;
        run(1700, 1'b1);
        pix_en = 1'b0;
        repeat (3) @(negedge clk);

        // Move to DrawX=300 on the default mode, then reset mid-line.
        k = 0;
        while (((steps - 1) % 800) != 300 && k < 2000) begin
            run(1, 1'b0);
            k++;
        end
        check("reach_x300", int'(d0_x), 300);
        rst_n  = 1'b0;
        pix_en = 1'b1;
        @(negedge clk);
        check("midrst_x", int'(d0_x), 0);
        check("midrst_y", int'(d0_y), 0);
        check("midrst_hs", int'(d0_hs), 1);
        check("midrst_vs", int'(d0_vs), 1);
        check("midrst_blank_n", int'(d0_bn), 0);
        check("midrst_new_line", int'(d0_nl), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart_new_frame", int'(d0_nf), 1);
        check("restart_x", int'(d0_x), 0);

        // A Match_Y beyond the last line must never fire. Then restore 5.
        match_y = 10'd9;
        run(300, 1'b0);
        match_y = 10'd5;
        run(230, 1'b0);

        pix_en   = 1'b0;
        @(negedge clk);
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
